// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multicycle control unit and the ULA:
// ALU operation codes, opcode classes, select encodings and FSM states.
package mips_pkg;

    localparam int unsigned ALU_W   = 4;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 4;

    // ULA operation codes; values 1010..1111 are branch comparisons.
    typedef enum logic [ALU_W-1:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_MUL = 4'b0010,
        ALU_DIV = 4'b0011,
        ALU_AND = 4'b0100,
        ALU_OR  = 4'b0101,
        ALU_NOT = 4'b0110,
        ALU_SL  = 4'b0111,
        ALU_SR  = 4'b1000,
        ALU_SLT = 4'b1001,
        ALU_BEQ = 4'b1010,
        ALU_BNE = 4'b1011,
        ALU_BGT = 4'b1100,
        ALU_BLT = 4'b1101,
        ALU_BGE = 4'b1110,
        ALU_BLE = 4'b1111
    } alu_op_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b000001;
    localparam logic [OP_W-1:0] OP_SW    = 6'b000010;
    localparam logic [OP_W-1:0] OP_J     = 6'b000011;
    localparam logic [OP_W-1:0] OP_HALT  = 6'b111111;

    // Op[5:4] prefixes carrying an ALU code in Op[3:0].
    localparam logic [1:0] OP_CLS_ALU_I  = 2'b01;
    localparam logic [1:0] OP_CLS_BRANCH = 2'b10;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC_R,
        ST_EXEC_I,
        ST_WB_R,
        ST_WB_I,
        ST_MEM_ADDR,
        ST_MEM_RD,
        ST_MEM_WR,
        ST_MEM_WB,
        ST_BRANCH,
        ST_JUMP,
        ST_HALT,
        ST_FAULT
    } state_e;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_BRANCH,
        CLS_LW,
        CLS_SW,
        CLS_JUMP,
        CLS_HALT,
        CLS_ILLEGAL
    } instr_cls_e;

    // Moore part of the datapath control word.
    typedef struct packed {
        logic [ALU_W-1:0] alu_op;
        logic             alu_src_a;
        logic [1:0]       alu_src_b;
        logic [1:0]       pc_source;
        logic             pc_write;
        logic             mem_read;
        logic             mem_write;
        logic             ior_d;
        logic             reg_write;
        logic             reg_dst;
        logic             mem_to_reg;
        logic             halt;
        logic             fault;
    } ctrl_t;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control-unit <-> datapath bundle: instruction fields and status in,
// ALU operation, mux selects and write enables out.
interface mips_multicycle_control_if;
    import mips_pkg::*;

    logic [OP_W-1:0]    Op;
    logic [FUNCT_W-1:0] Funct;
    logic               Zero;
    logic               MemReady;

    logic [ALU_W-1:0]   ALUOp;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         PCSource;
    logic               PCWrite;
    logic               IRWrite;
    logic               MemRead;
    logic               MemWrite;
    logic               IorD;
    logic               RegWrite;
    logic               RegDst;
    logic               MemToReg;
    logic               Halt;
    logic               Fault;

    modport master (
        input  Op, Funct, Zero, MemReady,
        output ALUOp, ALUSrcA, ALUSrcB, PCSource, PCWrite, IRWrite,
               MemRead, MemWrite, IorD, RegWrite, RegDst, MemToReg,
               Halt, Fault
    );

    modport slave (
        output Op, Funct, Zero, MemReady,
        input  ALUOp, ALUSrcA, ALUSrcB, PCSource, PCWrite, IRWrite,
               MemRead, MemWrite, IorD, RegWrite, RegDst, MemToReg,
               Halt, Fault
    );

endinterface

// File: rtl/mips_opcode_decode.sv
// Combinational instruction classifier: maps {Op, Funct} to an instruction
// class, the ALU operation it needs and an illegal-encoding flag.
module mips_opcode_decode
    import mips_pkg::*;
(
    input  logic [OP_W-1:0]    op_i,
    input  logic [FUNCT_W-1:0] funct_i,
    output instr_cls_e         cls_o,
    output logic [ALU_W-1:0]   alu_op_o,
    output logic               illegal_o
);

    logic [ALU_W-1:0] op_code;

    assign op_code = op_i[ALU_W-1:0];

    always_comb begin
        cls_o    = CLS_ILLEGAL;
        alu_op_o = ALU_ADD;
        if (op_i == OP_RTYPE) begin
            alu_op_o = funct_i;
            cls_o    = (funct_i <= ALU_SLT) ? CLS_R : CLS_ILLEGAL;
        end else if (op_i[OP_W-1:OP_W-2] == OP_CLS_ALU_I) begin
            alu_op_o = op_code;
            cls_o    = (op_code <= ALU_SLT) ? CLS_I : CLS_ILLEGAL;
        end else if (op_i[OP_W-1:OP_W-2] == OP_CLS_BRANCH) begin
            // Only the comparison codes are meaningful as branch conditions.
            alu_op_o = op_code;
            cls_o    = (op_code >= ALU_BEQ) ? CLS_BRANCH : CLS_ILLEGAL;
        end else begin
            case (op_i)
                OP_LW:   cls_o = CLS_LW;
                OP_SW:   cls_o = CLS_SW;
                OP_J:    cls_o = CLS_JUMP;
                OP_HALT: cls_o = CLS_HALT;
                default: cls_o = CLS_ILLEGAL;
            endcase
        end
    end

    assign illegal_o = (cls_o == CLS_ILLEGAL);

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/
// writeback, handshakes with wait-state memory and drives the ULA ALUOp.
module mips_multicycle_control
    import mips_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 0,
    parameter int unsigned TO_W        = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    mips_multicycle_control_if.master ctl_bus
);

    state_e           state_q, state_d;
    logic             run_q;
    logic [TO_W-1:0]  wait_q, wait_d;
    ctrl_t            ctrl_q, ctrl_d;

    instr_cls_e       dec_cls;
    logic [ALU_W-1:0] dec_alu_op;
    logic             dec_illegal;

    logic             timeout_c;
    logic             fetch_done_c;
    logic             branch_take_c;

    mips_opcode_decode u_decode (
        .op_i      (ctl_bus.Op),
        .funct_i   (ctl_bus.Funct),
        .cls_o     (dec_cls),
        .alu_op_o  (dec_alu_op),
        .illegal_o (dec_illegal)
    );

    // Fault when this wait cycle would bring the counter up to the limit.
    assign timeout_c = (MEM_TIMEOUT != 0) && !ctl_bus.MemReady &&
                       ((32'(wait_q) + 32'd1) >= MEM_TIMEOUT);

    assign fetch_done_c  = run_q && (state_q == ST_FETCH) && ctl_bus.MemReady;
    assign branch_take_c = (state_q == ST_BRANCH) && ctl_bus.Zero;

    // Next state and wait counter; the counter is zero on every state entry.
    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        if (run_q) begin
            case (state_q)
                ST_FETCH, ST_MEM_RD, ST_MEM_WR: begin
                    if (ctl_bus.MemReady) begin
                        if (state_q == ST_FETCH)       state_d = ST_DECODE;
                        else if (state_q == ST_MEM_RD) state_d = ST_MEM_WB;
                        else                           state_d = ST_FETCH;
                    end else if (timeout_c) begin
                        state_d = ST_FAULT;
                    end else begin
                        wait_d = (wait_q == '1) ? wait_q : wait_q + TO_W'(1);
                    end
                end
                ST_DECODE: begin
                    if (dec_illegal) begin
                        state_d = ST_FAULT;
                    end else begin
                        case (dec_cls)
                            CLS_R:          state_d = ST_EXEC_R;
                            CLS_I:          state_d = ST_EXEC_I;
                            CLS_BRANCH:     state_d = ST_BRANCH;
                            CLS_LW, CLS_SW: state_d = ST_MEM_ADDR;
                            CLS_JUMP:       state_d = ST_JUMP;
                            CLS_HALT:       state_d = ST_HALT;
                            default:        state_d = ST_FAULT;
                        endcase
                    end
                end
                ST_EXEC_R:   state_d = ST_WB_R;
                ST_EXEC_I:   state_d = ST_WB_I;
                ST_MEM_ADDR: state_d = (dec_cls == CLS_SW) ? ST_MEM_WR : ST_MEM_RD;
                ST_WB_R, ST_WB_I, ST_MEM_WB, ST_BRANCH, ST_JUMP:
                             state_d = ST_FETCH;
                ST_HALT:     state_d = ST_HALT;
                ST_FAULT:    state_d = ST_FAULT;
                default:     state_d = ST_FAULT;
            endcase
        end
    end

    // Moore control word for the state being entered, so it is registered
    // alongside the state; ALUOp is captured from the stable IR fields.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            ST_FETCH: begin
                ctrl_d.mem_read  = 1'b1;
                ctrl_d.alu_src_b = SRCB_FOUR;
                ctrl_d.pc_source = PCSRC_ALU;
                ctrl_d.alu_op    = ALU_ADD;
            end
            ST_DECODE: begin
                ctrl_d.alu_src_b = SRCB_IMM_SH2;
                ctrl_d.alu_op    = ALU_ADD;
            end
            ST_EXEC_R: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = SRCB_REG;
                ctrl_d.alu_op    = dec_alu_op;
            end
            ST_EXEC_I: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = SRCB_IMM;
                ctrl_d.alu_op    = dec_alu_op;
            end
            ST_WB_R: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.reg_dst   = 1'b1;
            end
            ST_WB_I: ctrl_d.reg_write = 1'b1;
            ST_MEM_ADDR: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = SRCB_IMM;
                ctrl_d.alu_op    = ALU_ADD;
            end
            ST_MEM_RD: begin
                ctrl_d.mem_read = 1'b1;
                ctrl_d.ior_d    = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.ior_d     = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = SRCB_REG;
                ctrl_d.alu_op    = dec_alu_op;
                ctrl_d.pc_source = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                ctrl_d.pc_write  = 1'b1;
                ctrl_d.pc_source = PCSRC_JUMP;
            end
            ST_HALT: ctrl_d.halt = 1'b1;
            ST_FAULT: begin
                ctrl_d.halt  = 1'b1;
                ctrl_d.fault = 1'b1;
            end
            default: ctrl_d = '0;
        endcase
    end

    // run_q holds the unit idle (outputs low) until the first edge after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
            run_q   <= 1'b0;
            wait_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            wait_q  <= wait_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign ctl_bus.ALUOp    = ctrl_q.alu_op;
    assign ctl_bus.ALUSrcA  = ctrl_q.alu_src_a;
    assign ctl_bus.ALUSrcB  = ctrl_q.alu_src_b;
    assign ctl_bus.PCSource = ctrl_q.pc_source;
    assign ctl_bus.PCWrite  = ctrl_q.pc_write | fetch_done_c | branch_take_c;
    assign ctl_bus.IRWrite  = fetch_done_c;
    assign ctl_bus.MemRead  = ctrl_q.mem_read;
    assign ctl_bus.MemWrite = ctrl_q.mem_write;
    assign ctl_bus.IorD     = ctrl_q.ior_d;
    assign ctl_bus.RegWrite = ctrl_q.reg_write;
    assign ctl_bus.RegDst   = ctrl_q.reg_dst;
    assign ctl_bus.MemToReg = ctrl_q.mem_to_reg;
    assign ctl_bus.Halt     = ctrl_q.halt;
    assign ctl_bus.Fault    = ctrl_q.fault;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Cycle-level bench for the multicycle control unit: expected control words
// are queued as each cycle's inputs are driven and compared when sampled.
module tb_mips_multicycle_control;

    typedef struct packed {
        logic [3:0] aluop;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic       pcw;
        logic       irw;
        logic       mrd;
        logic       mwr;
        logic       iord;
        logic       rw;
        logic       rdst;
        logic       m2r;
        logic       halt;
        logic       fault;
    } outv_t;

    localparam int K_RST   = 0;
    localparam int K_FETCH = 1;
    localparam int K_DEC   = 2;
    localparam int K_EXR   = 3;
    localparam int K_EXI   = 4;
    localparam int K_WBR   = 5;
    localparam int K_WBI   = 6;
    localparam int K_MA    = 7;
    localparam int K_MRD   = 8;
    localparam int K_MWR   = 9;
    localparam int K_MWB   = 10;
    localparam int K_BR    = 11;
    localparam int K_J     = 12;
    localparam int K_HALT  = 13;
    localparam int K_FAULT = 14;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_err;

    outv_t exp_q[$];
    outv_t exp1_q[$];

    mips_multicycle_control_if bus0 ();
    mips_multicycle_control_if bus1 ();

    mips_multicycle_control #(.MEM_TIMEOUT(0), .TO_W(8)) dut0 (
        .clock   (clock),
        .reset   (reset),
        .ctl_bus (bus0.master)
    );

    mips_multicycle_control #(.MEM_TIMEOUT(5), .TO_W(4)) dut1 (
        .clock   (clock),
        .reset   (reset),
        .ctl_bus (bus1.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected outputs for one cycle in the given state class.
    function automatic outv_t ev(input int k, input logic [3:0] c, input logic b);
        outv_t v;
        v = '0;
        case (k)
            K_FETCH: begin v.srcb = 2'b01; v.mrd = 1'b1; v.irw = b; v.pcw = b; end
            K_DEC:   v.srcb = 2'b11;
            K_EXR:   begin v.srca = 1'b1; v.srcb = 2'b00; v.aluop = c; end
            K_EXI:   begin v.srca = 1'b1; v.srcb = 2'b10; v.aluop = c; end
            K_WBR:   begin v.rw = 1'b1; v.rdst = 1'b1; end
            K_WBI:   v.rw = 1'b1;
            K_MA:    begin v.srca = 1'b1; v.srcb = 2'b10; end
            K_MRD:   begin v.mrd = 1'b1; v.iord = 1'b1; end
            K_MWR:   begin v.mwr = 1'b1; v.iord = 1'b1; end
            K_MWB:   begin v.rw = 1'b1; v.m2r = 1'b1; end
            K_BR:    begin v.srca = 1'b1; v.aluop = c; v.pcsrc = 2'b01; v.pcw = b; end
            K_J:     begin v.pcw = 1'b1; v.pcsrc = 2'b10; end
            K_HALT:  v.halt = 1'b1;
            K_FAULT: begin v.halt = 1'b1; v.fault = 1'b1; end
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic outv_t obs0();
        return {bus0.ALUOp, bus0.ALUSrcA, bus0.ALUSrcB, bus0.PCSource,
                bus0.PCWrite, bus0.IRWrite, bus0.MemRead, bus0.MemWrite,
                bus0.IorD, bus0.RegWrite, bus0.RegDst, bus0.MemToReg,
                bus0.Halt, bus0.Fault};
    endfunction

    function automatic outv_t obs1();
        return {bus1.ALUOp, bus1.ALUSrcA, bus1.ALUSrcB, bus1.PCSource,
                bus1.PCWrite, bus1.IRWrite, bus1.MemRead, bus1.MemWrite,
                bus1.IorD, bus1.RegWrite, bus1.RegDst, bus1.MemToReg,
                bus1.Halt, bus1.Fault};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle on dut0: drive handshake inputs, queue expectation, sample.
    task automatic step(input logic rdy, input logic z, input int k,
                        input logic [3:0] c, input logic b, input string tag);
        @(negedge clock);
        bus0.MemReady = rdy;
        bus0.Zero     = z;
        exp_q.push_back(ev(k, c, b));
        #2;
        check_eq(tag, 32'(obs0()), 32'(exp_q.pop_front()));
    endtask

    task automatic do_fetch(input logic [5:0] op, input logic [3:0] fn,
                            input int waits, input string tag);
        bus0.Op    = op;
        bus0.Funct = fn;
        for (int i = 0; i < waits; i++) step(1'b0, 1'b0, K_FETCH, 4'h0, 1'b0, {tag, "_fwait"});
        step(1'b1, 1'b0, K_FETCH, 4'h0, 1'b1, {tag, "_fetch"});
    endtask

    task automatic rst_pulse(input string tag);
        @(negedge clock);
        bus0.MemReady = 1'b0;
        reset = 1'b1;
        exp_q.push_back(ev(K_RST, 4'h0, 1'b0));
        #2;
        check_eq(tag, 32'(obs0()), 32'(exp_q.pop_front()));
        #1 reset = 1'b0;
    endtask

    task automatic illegal_case(input logic [5:0] op, input logic [3:0] fn, input string tag);
        do_fetch(op, fn, 0, tag);
        step(1'b1, 1'b0, K_DEC, 4'h0, 1'b0, {tag, "_dec"});
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, K_FAULT, 4'h0, 1'b0, {tag, "_fault"});
        rst_pulse({tag, "_rst"});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus0.Op = 6'd0; bus0.Funct = 4'd0; bus0.Zero = 1'b0; bus0.MemReady = 1'b0;
        bus1.Op = 6'd0; bus1.Funct = 4'd0; bus1.Zero = 1'b0; bus1.MemReady = 1'b0;

        @(negedge clock);
        exp_q.push_back(ev(K_RST, 4'h0, 1'b0));
        exp1_q.push_back(ev(K_RST, 4'h0, 1'b0));
        #2;
        check_eq("reset_dut0", 32'(obs0()), 32'(exp_q.pop_front()));
        check_eq("reset_dut1", 32'(obs1()), 32'(exp1_q.pop_front()));
        #1 reset = 1'b0;

        // Stuck memory: dut1 faults after 5 waiting FETCH cycles, dut0 waits on.
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            bus0.MemReady = 1'b0;
            exp_q.push_back(ev(K_FETCH, 4'h0, 1'b0));
            exp1_q.push_back(i < 5 ? ev(K_FETCH, 4'h0, 1'b0) : ev(K_FAULT, 4'h0, 1'b0));
            #2;
            check_eq("timeout_dut0", 32'(obs0()), 32'(exp_q.pop_front()));
            check_eq("timeout_dut1", 32'(obs1()), 32'(exp1_q.pop_front()));
        end

        // R-type sub
        do_fetch(6'b000000, 4'b0001, 0, "r_sub");
        step(1'b1, 1'b0, K_DEC, 4'h0, 1'b0, "r_sub_dec");
        step(1'b1, 1'b0, K_EXR, 4'b0001, 1'b0, "r_sub_exec");
        step(1'b1, 1'b0, K_WBR, 4'h0, 1'b0, "r_sub_wb");

        // R-type slt (highest legal funct), fetch with two wait states
        do_fetch(6'b000000, 4'b1001, 2, "r_slt");
        step(1'b0, 1'b0, K_DEC, 4'h0, 1'b0, "r_slt_dec");
        step(1'b1, 1'b0, K_EXR, 4'b1001, 1'b0, "r_slt_exec");
        step(1'b0, 1'b0, K_WBR, 4'h0, 1'b0, "r_slt_wb");

        // I-type and / slt
        do_fetch(6'b010100, 4'b0111, 0, "i_and");
        step(1'b1, 1'b0, K_DEC, 4'h0, 1'b0, "i_and_dec");
        step(1'b1, 1'b0, K_EXI, 4'b0100, 1'b0, "i_and_exec");
        step(1'b1, 1'b0, K_WBI, 4'h0, 1'b0, "i_and_wb");
        do_fetch(6'b011001, 4'b0000, 0, "i_slt");
        step(1'b1, 1'b0, K_DEC, 4'h0, 1'b0, "i_slt_dec");
        step(1'b1, 1'b0, K_EXI, 4'b1001, 1'b0, "i_slt_exec");
        step(1'b1, 1'b0, K_WBI, 4'h0, 1'b0, "i_slt_wb");

        // lw with three data wait states
        do_fetch(6'b000001, 4'h0, 0, "lw");
        step(1'b1, 1'b0, K_DEC, 4'h0, 1'b0, "lw_dec");
        step(1'b1, 1'b0, K_MA, 4'h0, 1'b0, "lw_addr");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, K_MRD, 4'h0, 1'b0, "lw_rd_wait");
        step(1'b1, 1'b0, K_MRD, 4'h0, 1'b0, "lw_rd_done");
        step(1'b1, 1'b0, K_MWB, 4'h0, 1'b0, "lw_wb");

        // sw with one wait state
        do_fetch(6'b000010, 4'h0, 0, "sw");
        step(1'b1, 1'b0, K_DEC, 4'h0, 1'b0, "sw_dec");
        step(1'b0, 1'b0, K_MA, 4'h0, 1'b0, "sw_addr");
        step(1'b0, 1'b0, K_MWR, 4'h0, 1'b0, "sw_wr_wait");
        step(1'b1, 1'b0, K_MWR, 4'h0, 1'b0, "sw_wr_done");

        // beq taken / not taken; Zero in DECODE must not write PC
        do_fetch(6'b101010, 4'h0, 0, "beq_t");
        step(1'b1, 1'b1, K_DEC, 4'h0, 1'b0, "beq_t_dec");
        step(1'b1, 1'b1, K_BR, 4'b1010, 1'b1, "beq_t_br");
        do_fetch(6'b101010, 4'h0, 0, "beq_n");
        step(1'b1, 1'b0, K_DEC, 4'h0, 1'b0, "beq_n_dec");
        step(1'b1, 1'b0, K_BR, 4'b1010, 1'b0, "beq_n_br");
        do_fetch(6'b101111, 4'h0, 0, "ble");
        step(1'b1, 1'b0, K_DEC, 4'h0, 1'b0, "ble_dec");
        step(1'b1, 1'b1, K_BR, 4'b1111, 1'b1, "ble_br");

        // jump
        do_fetch(6'b000011, 4'h0, 0, "j");
        step(1'b1, 1'b0, K_DEC, 4'h0, 1'b0, "j_dec");
        step(1'b1, 1'b0, K_J, 4'h0, 1'b0, "j_jump");

        // illegal encodings
        illegal_case(6'b011100, 4'h0, "ill_i");
        illegal_case(6'b100011, 4'h0, "ill_br");
        illegal_case(6'b000100, 4'h0, "ill_op");
        illegal_case(6'b000000, 4'b1010, "ill_funct");

        // halt
        do_fetch(6'b111111, 4'h0, 0, "halt");
        step(1'b1, 1'b0, K_DEC, 4'h0, 1'b0, "halt_dec");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, K_HALT, 4'h0, 1'b0, "halt_hold");
        rst_pulse("halt_rst");

        // reset in the middle of a lw data wait
        do_fetch(6'b000001, 4'h0, 0, "lw_rst");
        step(1'b1, 1'b0, K_DEC, 4'h0, 1'b0, "lw_rst_dec");
        step(1'b1, 1'b0, K_MA, 4'h0, 1'b0, "lw_rst_addr");
        step(1'b0, 1'b0, K_MRD, 4'h0, 1'b0, "lw_rst_wait");
        step(1'b0, 1'b0, K_MRD, 4'h0, 1'b0, "lw_rst_wait");
        rst_pulse("mid_wait_rst");
        step(1'b0, 1'b0, K_FETCH, 4'h0, 1'b0, "post_rst_fetch");
        do_fetch(6'b000011, 4'h0, 0, "post_rst_j");
        step(1'b1, 1'b0, K_DEC, 4'h0, 1'b0, "post_rst_j_dec");
        step(1'b1, 1'b0, K_J, 4'h0, 1'b0, "post_rst_j_jump");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multicycle control unit for the MIPS datapath, and the driving end of the ULA interface: it generates ALUOp every cycle and consumes the ULA Zero (branch-condition) output.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Handshakes with instruction/data memory, which may insert wait states.
- Drives all datapath mux selects and write enables.

Parameters:
- MEM_TIMEOUT, default 0, meaning: max wait cycles per memory access before the unit faults; 0 = unlimited.
- TO_W, default 8, meaning: width of the wait-cycle counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; forces FETCH and clears all outputs.
- Op  in  6  instruction opcode, IR[31:26].
- Funct  in  4  R-type function field, IR[3:0].
- Zero  in  1  ULA branch-condition result.
- MemReady  in  1  memory completes the current access this cycle.
- ALUOp  out  4  operation code to ULA.
- ALUSrcA  out  1  0 = PC, 1 = register A.
- ALUSrcB  out  2  00 = register B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm<<2.
- PCSource  out  2  00 = ULA result, 01 = ALUOut, 10 = jump target.
- PCWrite, IRWrite, MemRead, MemWrite, IorD, RegWrite, RegDst, MemToReg  out  1 each  standard datapath controls.
- Halt  out  1  sticky; asserted in HALT or FAULT.
- Fault  out  1  sticky; illegal opcode or memory timeout.

Behaviour:
- Reset (async, any state, including mid memory wait):
  - state = FETCH, wait counter = 0.
  - Every output 0, including ALUOp = 0000, Halt = 0, Fault = 0.
  - First fetch begins on the first clock edge after reset deasserts.
- ALUOp encoding:
  - 0000 add, 0001 sub, 0010 mul, 0011 div, 0100 and, 0101 or, 0110 not, 0111 sl, 1000 sr, 1001 slt.
  - 1010 beq, 1011 bne, 1100 bgt, 1101 blt, 1110 bge, 1111 ble.
- Decode table:
  - Op = 000000: R-type, ALUOp = Funct; Funct > 1001 is illegal.
  - Op = 01cccc: I-type ALU, ALUOp = cccc; cccc > 1001 is illegal.
  - Op = 10cccc: branch, ALUOp = cccc; cccc < 1010 is illegal.
  - Op = 000001: lw. Op = 000010: sw. Op = 000011: j. Op = 111111: halt.
  - Every other opcode is illegal.
- States and outputs (unlisted outputs are 0):
  - FETCH: MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 0000.
    - Stays in FETCH while MemReady = 0.
    - On MemReady = 1, same cycle: IRWrite = 1, PCWrite = 1, PCSource = 00; next state DECODE.
  - DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 0000 (branch target into ALUOut). Next state per decode table; illegal opcode -> FAULT.
  - EXEC_R: ALUSrcA = 1, ALUSrcB = 00, ALUOp = Funct -> WB_R.
  - EXEC_I: ALUSrcA = 1, ALUSrcB = 10, ALUOp = Op[3:0] -> WB_I.
  - WB_R: RegWrite = 1, RegDst = 1, MemToReg = 0 -> FETCH.
  - WB_I: RegWrite = 1, RegDst = 0, MemToReg = 0 -> FETCH.
  - MEM_ADDR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 0000 -> MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD: MemRead = 1, IorD = 1; waits for MemReady -> MEM_WB.
  - MEM_WR: MemWrite = 1, IorD = 1; waits for MemReady -> FETCH.
  - MEM_WB: RegWrite = 1, RegDst = 0, MemToReg = 1 -> FETCH.
  - BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = Op[3:0], PCSource = 01, PCWrite = Zero (combinational, same cycle) -> FETCH.
  - JUMP: PCWrite = 1, PCSource = 10 -> FETCH.
  - HALT: Halt = 1; terminal until reset.
  - FAULT: Halt = 1, Fault = 1; terminal until reset.
- Memory handshake:
  - MemRead/MemWrite stay asserted, with IorD stable, until the cycle MemReady = 1 is sampled.
  - MemReady outside FETCH/MEM_RD/MEM_WR is ignored.
- Timeout:
  - Wait counter clears on entry to each memory state and increments each cycle with MemReady = 0.
  - If MEM_TIMEOUT != 0 and the counter reaches MEM_TIMEOUT with MemReady still 0 -> FAULT.
  - The counter saturates at its maximum value and never wraps.
- Latencies with zero-wait memory: R/I-type 4 cycles, lw 5, sw 4, branch 3, j 3.
- Outputs are Moore-decoded from state. The only Mealy terms are PCWrite/IRWrite (on MemReady in FETCH) and PCWrite (on Zero in BRANCH).

Decomposition:
- Shared package mips_pkg:
  - ALUOp localparams (ALU_ADD … ALU_BLE), shared with ULA.
  - Opcode constants and the ALUSrcB/PCSource select encodings.
  - State enumeration.
- One natural sub-module: mips_opcode_decode, a combinational block mapping {Op, Funct} to next-state class, ALUOp and illegal flag.

Test Plan:
- Reset mid MEM_RD wait (MemReady = 0): reset pulse -> all outputs 0 immediately, state FETCH, Halt = 0, Fault = 0.
- R-type Op = 000000, Funct = 0001, MemReady always 1 -> FETCH, DECODE, EXEC_R (ALUOp = 0001, ALUSrcA = 1, ALUSrcB = 00), WB_R (RegWrite = 1, RegDst = 1); back in FETCH on cycle 5.
- lw with MemReady low for 3 cycles in MEM_RD -> MemRead = 1 and IorD = 1 held 4 cycles, then MEM_WB with MemToReg = 1, RegWrite = 1.
- Branch Op = 101010 (beq): Zero = 1 -> PCWrite = 1, PCSource = 01, ALUOp = 1010. Repeat with Zero = 0 -> PCWrite = 0. Both return to FETCH.
- Illegal Op = 011100, and separately Op = 100011 -> FAULT after DECODE; Halt = Fault = 1 held until reset. Op = 111111 -> Halt = 1, Fault = 0.
- MEM_TIMEOUT = 5, MemReady stuck 0 in FETCH -> FAULT entered after exactly 5 wait cycles; MemRead deasserts in FAULT.
